// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store unit: FSM states, load/store funct3 encodings
// and the funct3 legality check.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } mau_state_t;

    typedef enum logic [2:0] {
        LF3_LB  = 3'b000,
        LF3_LH  = 3'b001,
        LF3_LW  = 3'b010,
        LF3_LD  = 3'b011,
        LF3_LBU = 3'b100,
        LF3_LHU = 3'b101,
        LF3_LWU = 3'b110
    } load_funct3_t;

    typedef enum logic [2:0] {
        SF3_SB = 3'b000,
        SF3_SH = 3'b001,
        SF3_SW = 3'b010,
        SF3_SD = 3'b011
    } store_funct3_t;

    // Doubleword encodings only exist on a 64-bit data path.
    function automatic logic mau_funct3_legal(input logic we, input logic [2:0] f3, input bit wide);
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (f3)
                SF3_SB, SF3_SH, SF3_SW: ok = 1'b1;
                SF3_SD:                 ok = wide;
                default:                ok = 1'b0;
            endcase
        end else begin
            case (f3)
                LF3_LB, LF3_LH, LF3_LW, LF3_LBU, LF3_LHU: ok = 1'b1;
                LF3_LD, LF3_LWU:                          ok = wide;
                default:                                  ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load aligner: shifts the requested bytes of one or two beats
// down to lane 0 and sign- or zero-extends them to DATA_W.
module mau_load_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFS_W  = 2
) (
    input  logic [DATA_W-1:0] i_lo,
    input  logic [DATA_W-1:0] i_hi,
    input  logic [OFS_W-1:0]  i_ofs,
    input  logic [2:0]        i_funct3,
    output logic [DATA_W-1:0] o_data
);

    logic [2*DATA_W-1:0] w_pair;
    logic [DATA_W-1:0]   w_lane;
    logic [DATA_W-1:0]   w_keep;
    logic                w_sign;

    // Beat 0 supplies the low bytes of the result, beat 1 the overflow bytes.
    assign w_pair = {i_hi, i_lo} >> {i_ofs, 3'b000};
    assign w_lane = w_pair[DATA_W-1:0];

    always_comb begin
        w_keep = '1;
        w_sign = 1'b0;
        case (i_funct3[1:0])
            2'd0:    begin w_keep = DATA_W'(8'hFF);         w_sign = w_lane[7];        end
            2'd1:    begin w_keep = DATA_W'(16'hFFFF);      w_sign = w_lane[15];       end
            2'd2:    begin w_keep = DATA_W'(32'hFFFF_FFFF); w_sign = w_lane[31];       end
            default: begin w_keep = '1;                     w_sign = w_lane[DATA_W-1]; end
        endcase
        if (i_funct3[2]) begin
            w_sign = 1'b0;
        end
    end

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
        assign o_data[gi] = w_keep[gi] ? w_lane[gi] : w_sign;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Sequenced load/store unit with byte enables and load extension.
// Define MAU_MISALIGNED_EN to split word-crossing accesses into two beats.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byte_enable,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_resp
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);
    localparam bit WIDE  = (DATA_W == 64);
`ifdef MAU_MISALIGNED_EN
    localparam int SPAN = 2;
`else
    localparam int SPAN = 1;
`endif
    localparam int PAIR_BE_W = SPAN * BYTES;
    localparam int PAIR_D_W  = SPAN * DATA_W;

    mau_state_t r_state, w_state_next;

    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              r_req_ready, r_resp_valid, r_resp_err, r_mem_read, r_mem_write;
    logic [DATA_W-1:0] r_resp_rdata, r_mem_wdata;
    logic [ADDR_W-1:0] r_mem_address;
    logic [BYTES-1:0]  r_mem_byte_enable;

    logic              w_req_ready_next, w_resp_valid_next, w_resp_err_next, w_mem_read_next, w_mem_write_next;
    logic [DATA_W-1:0] w_resp_rdata_next, w_mem_wdata_next;
    logic [ADDR_W-1:0] w_mem_address_next;
    logic [BYTES-1:0]  w_mem_byte_enable_next;

    logic                 w_accept, w_cur_we, w_bad;
    logic [2:0]           w_cur_funct3;
    logic [ADDR_W-1:0]    w_cur_addr, w_base_addr;
    logic [DATA_W-1:0]    w_cur_wdata, w_align_lo, w_align_hi, w_load_data;
    logic [OFS_W-1:0]     w_ofs;
    logic [2*BYTES-1:0]   w_size_mask;
    logic [PAIR_BE_W-1:0] w_be_pair;
    logic [PAIR_D_W-1:0]  w_wdata_pair;

    // Decode from the live request in the accept cycle, from the latched copy afterwards.
    assign w_accept     = r_req_ready & req_valid;
    assign w_cur_we     = w_accept ? req_we     : r_we;
    assign w_cur_funct3 = w_accept ? req_funct3 : r_funct3;
    assign w_cur_addr   = w_accept ? req_addr   : r_addr;
    assign w_cur_wdata  = w_accept ? req_wdata  : r_wdata;
    assign w_ofs        = w_cur_addr[OFS_W-1:0];
    assign w_base_addr  = {w_cur_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

    always_comb begin
        case (w_cur_funct3[1:0])
            2'd0:    w_size_mask = (2*BYTES)'(8'h01);
            2'd1:    w_size_mask = (2*BYTES)'(8'h03);
            2'd2:    w_size_mask = (2*BYTES)'(8'h0F);
            default: w_size_mask = (2*BYTES)'(8'hFF);
        endcase
    end

    assign w_be_pair    = PAIR_BE_W'(w_size_mask << w_ofs);
    assign w_wdata_pair = PAIR_D_W'({{DATA_W{1'b0}}, w_cur_wdata} << {w_ofs, 3'b000});

`ifdef MAU_MISALIGNED_EN
    logic              w_split;
    logic [DATA_W-1:0] r_hold;

    assign w_split    = |w_be_pair[2*BYTES-1:BYTES];
    assign w_bad      = ~mau_funct3_legal(w_cur_we, w_cur_funct3, WIDE);
    assign w_align_lo = (r_state == BEAT1) ? r_hold : mem_rdata;
    assign w_align_hi = (r_state == BEAT1) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (r_state == BEAT0 && mem_resp) begin
            r_hold <= mem_rdata;
        end
    end
`else
    logic [OFS_W-1:0] w_ofs_mask;

    assign w_ofs_mask = OFS_W'((4'd1 << w_cur_funct3[1:0]) - 4'd1);
    assign w_bad      = ~mau_funct3_legal(w_cur_we, w_cur_funct3, WIDE) | (|(w_ofs & w_ofs_mask));
    assign w_align_lo = mem_rdata;
    assign w_align_hi = '0;
`endif

    mau_load_align #(
        .DATA_W (DATA_W),
        .OFS_W  (OFS_W)
    ) u_load_align (
        .i_lo     (w_align_lo),
        .i_hi     (w_align_hi),
        .i_ofs    (r_addr[OFS_W-1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_bad ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                if (mem_resp) begin
`ifdef MAU_MISALIGNED_EN
                    w_state_next = w_split ? BEAT1 : RESP;
`else
                    w_state_next = RESP;
`endif
                end
            end
`ifdef MAU_MISALIGNED_EN
            BEAT1: begin
                if (mem_resp) begin
                    w_state_next = RESP;
                end
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    // Memory and response outputs are computed for the next state and registered.
    always_comb begin
        w_req_ready_next       = (w_state_next == IDLE);
        w_resp_valid_next      = (w_state_next == RESP);
        w_resp_err_next        = (w_state_next == RESP) && (r_state == IDLE);
        w_resp_rdata_next      = '0;
        w_mem_read_next        = 1'b0;
        w_mem_write_next       = 1'b0;
        w_mem_address_next     = '0;
        w_mem_byte_enable_next = '0;
        w_mem_wdata_next       = '0;
        if (w_state_next == BEAT0) begin
            w_mem_read_next        = ~w_cur_we;
            w_mem_write_next       = w_cur_we;
            w_mem_address_next     = w_base_addr;
            w_mem_byte_enable_next = w_be_pair[BYTES-1:0];
            w_mem_wdata_next       = w_wdata_pair[DATA_W-1:0];
        end
`ifdef MAU_MISALIGNED_EN
        if (w_state_next == BEAT1) begin
            w_mem_read_next        = ~w_cur_we;
            w_mem_write_next       = w_cur_we;
            w_mem_address_next     = w_base_addr + ADDR_W'(BYTES);
            w_mem_byte_enable_next = w_be_pair[2*BYTES-1:BYTES];
            w_mem_wdata_next       = w_wdata_pair[2*DATA_W-1:DATA_W];
        end
`endif
        if (w_state_next == RESP && r_state != IDLE && !r_we) begin
            w_resp_rdata_next = w_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we              <= 1'b0;
            r_funct3          <= '0;
            r_addr            <= '0;
            r_wdata           <= '0;
            r_req_ready       <= 1'b0;
            r_resp_valid      <= 1'b0;
            r_resp_err        <= 1'b0;
            r_resp_rdata      <= '0;
            r_mem_read        <= 1'b0;
            r_mem_write       <= 1'b0;
            r_mem_address     <= '0;
            r_mem_byte_enable <= '0;
            r_mem_wdata       <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            r_req_ready       <= w_req_ready_next;
            r_resp_valid      <= w_resp_valid_next;
            r_resp_err        <= w_resp_err_next;
            r_resp_rdata      <= w_resp_rdata_next;
            r_mem_read        <= w_mem_read_next;
            r_mem_write       <= w_mem_write_next;
            r_mem_address     <= w_mem_address_next;
            r_mem_byte_enable <= w_mem_byte_enable_next;
            r_mem_wdata       <= w_mem_wdata_next;
        end
    end

    assign req_ready       = r_req_ready;
    assign resp_valid      = r_resp_valid;
    assign resp_err        = r_resp_err;
    assign resp_rdata      = r_resp_rdata;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_address     = r_mem_address;
    assign mem_byte_enable = r_mem_byte_enable;
    assign mem_wdata       = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit (DATA_W=32); expectations follow
// MAU_MISALIGNED_EN the same way the design build does.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    beat_t beat_q[$];
    resp_t resp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
        beat_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata; b.rdata = rdata; b.delay = delay;
        beat_q.push_back(b);
    endtask

    task automatic push_resp(input logic err, input logic [31:0] rdata);
        resp_t r;
        r.err = err; r.rdata = rdata;
        resp_q.push_back(r);
    endtask

    task automatic send(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    // Answers every queued beat, checking the strobes before and while it waits.
    task automatic serve(input string tag);
        beat_t b;
        int    n;
        while (beat_q.size() > 0) begin
            b = beat_q.pop_front();
            n = 0;
            while ((mem_read | mem_write) !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check({tag, "_rd"},   32'(mem_read),  32'(!b.we));
            check({tag, "_wr"},   32'(mem_write), 32'(b.we));
            check({tag, "_addr"}, mem_address, b.addr);
            check({tag, "_be"},   32'(mem_byte_enable), 32'(b.be));
            if (b.we) check({tag, "_wdata"}, mem_wdata, b.wdata);
            for (int i = 0; i < b.delay; i++) begin
                tick();
                check({tag, "_hold_addr"}, mem_address, b.addr);
                check({tag, "_hold_be"}, 32'(mem_byte_enable), 32'(b.be));
            end
            mem_rdata = b.rdata;
            mem_resp  = 1'b1;
            tick();
            mem_resp  = 1'b0;
            mem_rdata = '0;
        end
        check({tag, "_strobe_drop"}, 32'(mem_read | mem_write), 32'd0);
    endtask

    task automatic wait_resp(input string tag, input int max_wait);
        resp_t e;
        int    n;
        n = 0;
        while (resp_valid !== 1'b1 && n < max_wait) begin
            tick();
            n++;
        end
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        e = resp_q.pop_front();
        check({tag, "_err"},   32'(resp_err), 32'(e.err));
        check({tag, "_rdata"}, resp_rdata, e.rdata);
        $display("txn %s: err=%0d rdata=%h", tag, resp_err, resp_rdata);
        tick();
        check({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
        check({tag, "_ready_next"}, 32'(req_ready), 32'd1);
    endtask

    task automatic err_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        push_resp(1'b1, 32'd0);
        send(tag, we, f3, addr, wdata);
        check({tag, "_no_rd"}, 32'(mem_read), 32'd0);
        check({tag, "_no_wr"}, 32'(mem_write), 32'd0);
        wait_resp(tag, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_be", 32'(mem_byte_enable), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(req_ready), 32'd1);

        push_beat(1'b0, 32'h100, 4'hF, 32'h0, 32'h8BADF00D, 2);
        push_resp(1'b0, 32'h8BADF00D);
        send("lw", 1'b0, 3'b010, 32'h100, 32'h0);
        serve("lw");
        wait_resp("lw", 5);

        // Zero-latency memory: response must land at T+2.
        push_beat(1'b0, 32'h100, 4'b1000, 32'h0, 32'h80000000, 0);
        push_resp(1'b0, 32'hFFFFFF80);
        send("lb", 1'b0, 3'b000, 32'h103, 32'h0);
        serve("lb");
        wait_resp("lb", 0);

        push_beat(1'b0, 32'h100, 4'b1000, 32'h0, 32'h80000000, 0);
        push_resp(1'b0, 32'h00000080);
        send("lbu", 1'b0, 3'b100, 32'h103, 32'h0);
        serve("lbu");
        wait_resp("lbu", 0);

        push_beat(1'b0, 32'h200, 4'b1100, 32'h0, 32'h80011234, 1);
        push_resp(1'b0, 32'hFFFF8001);
        send("lh", 1'b0, 3'b001, 32'h202, 32'h0);
        serve("lh");
        wait_resp("lh", 5);

        push_beat(1'b0, 32'h200, 4'b1100, 32'h0, 32'h80011234, 0);
        push_resp(1'b0, 32'h00008001);
        send("lhu", 1'b0, 3'b101, 32'h202, 32'h0);
        serve("lhu");
        wait_resp("lhu", 5);

        push_beat(1'b1, 32'h100, 4'b1100, 32'hBEEF0000, 32'hFFFFFFFF, 0);
        push_resp(1'b0, 32'h0);
        send("sh", 1'b1, 3'b001, 32'h102, 32'h0000BEEF);
        serve("sh");
        wait_resp("sh", 5);

        push_beat(1'b1, 32'h300, 4'b0010, 32'h34567800, 32'h0, 1);
        push_resp(1'b0, 32'h0);
        send("sb", 1'b1, 3'b000, 32'h301, 32'h12345678);
        serve("sb");
        wait_resp("sb", 5);

`ifdef MAU_MISALIGNED_EN
        push_beat(1'b0, 32'h0FC, 4'b1100, 32'h0, 32'hAABB0000, 0);
        push_beat(1'b0, 32'h100, 4'b0011, 32'h0, 32'h0000DDCC, 0);
        push_resp(1'b0, 32'hDDCCAABB);
        send("lw_split", 1'b0, 3'b010, 32'h0FE, 32'h0);
        serve("lw_split");
        wait_resp("lw_split", 0);

        push_beat(1'b0, 32'h100, 4'b0110, 32'h0, 32'h00ABCD00, 0);
        push_resp(1'b0, 32'hFFFFABCD);
        send("lh_odd", 1'b0, 3'b001, 32'h101, 32'h0);
        serve("lh_odd");
        wait_resp("lh_odd", 5);

        push_beat(1'b1, 32'hFFFFFFFC, 4'b1100, 32'h33440000, 32'h0, 1);
        push_beat(1'b1, 32'h00000000, 4'b0011, 32'h00001122, 32'h0, 0);
        push_resp(1'b0, 32'h0);
        send("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'h11223344);
        serve("sw_wrap");
        wait_resp("sw_wrap", 5);
`else
        err_req("lw_misal", 1'b0, 3'b010, 32'h0FE, 32'h0);
        err_req("lh_odd", 1'b0, 3'b001, 32'h101, 32'h0);
        err_req("sw_misal", 1'b1, 3'b010, 32'hFFFFFFFE, 32'h11223344);
`endif

        err_req("sd_illegal", 1'b1, 3'b011, 32'h100, 32'h1);
        err_req("ld_illegal", 1'b0, 3'b011, 32'h100, 32'h0);
        err_req("l111_illegal", 1'b0, 3'b111, 32'h100, 32'h0);
        err_req("s100_illegal", 1'b1, 3'b100, 32'h100, 32'h0);

        // Reset while a load waits for memory; a later mem_resp must be ignored.
        send("rst_mid", 1'b0, 3'b010, 32'h400, 32'h0);
        check("rst_mid_rd", 32'(mem_read), 32'd1);
        check("rst_mid_addr", mem_address, 32'h400);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_rd_drop", 32'(mem_read), 32'd0);
        check("rst_mid_ready_low", 32'(req_ready), 32'd0);
        tick();
        check("rst_mid_ready_high", 32'(req_ready), 32'd1);
        mem_rdata = 32'hDEADBEEF;
        mem_resp  = 1'b1;
        tick();
        mem_resp  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_no_resp", 32'(resp_valid), 32'd0);
            check("rst_mid_no_rd", 32'(mem_read), 32'd0);
            tick();
        end
        $display("txn rst_mid: aborted by reset");

        push_beat(1'b0, 32'h104, 4'hF, 32'h0, 32'h00000001, 0);
        push_resp(1'b0, 32'h00000001);
        send("lw_after_rst", 1'b0, 3'b010, 32'h104, 32'h0);
        serve("lw_after_rst");
        wait_resp("lw_after_rst", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
